// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter in front of the core's single-port word memory.
// The fetch port and the load/store port share the memory through a
// three-state handshake (IDLE -> ISSUE -> RESP). Simultaneous requests
// are served round-robin. The LED register is decoded at the address
// LED_ADDR and never reaches the memory.
module mem_bus_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] LED_ADDR   = 32'hFFFF_FF00
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction-fetch port
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    // load/store port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [3:0]            d_wstrb,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    // memory side
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    // board LEDs
    output logic [7:0]            leds
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Owner / last-grant encoding: 0 = fetch port, 1 = data port.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    state_t state_reg, state_next;
    logic   owner_reg, owner_next;
    logic   led_sel_reg, led_sel_next;
    logic   last_grant_reg;
    logic [7:0] leds_reg;

    logic                  grant_d;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic                  led_wr;
    logic                  wstrb_en;
    logic [DATA_WIDTH-1:0] resp_word;

    // Byte-offset bits of the request addresses carry no meaning for a word memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    // On contention the data port wins only if fetch was served last.
    assign grant_d    = d_req && (!if_req || (last_grant_reg == OWN_IF));
    assign grant_addr = grant_d ? d_addr : if_addr;

    // LED register is written at the end of ISSUE by a data-port write hitting it with byte 0 enabled.
    assign led_wr = (state_reg == ST_ISSUE) && led_sel_reg && (owner_reg == OWN_D)
                    && d_we && d_wstrb[0];

    // State, owner, target latch, round-robin history and LED register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_IF;
            led_sel_reg    <= 1'b0;
            last_grant_reg <= OWN_D;
            leds_reg       <= 8'h00;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            led_sel_reg <= led_sel_next;
            if (state_reg == ST_RESP) begin
                last_grant_reg <= owner_reg;
            end
            if (led_wr) begin
                leds_reg <= d_wdata[7:0];
            end
        end
    end

    // Next-state logic: pick an owner in IDLE, then walk ISSUE and RESP.
    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        led_sel_next = led_sel_reg;
        case (state_reg)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    owner_next   = grant_d;
                    led_sel_next = (grant_addr[ADDR_WIDTH-1:2] == LED_ADDR[ADDR_WIDTH-1:2]);
                    state_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Write strobes are only meaningful for a data-port write.
    assign wstrb_en = (owner_reg == OWN_D) && d_we;

    // Memory request: driven straight from the owner's held inputs during ISSUE.
    // Since state resets asynchronously, mem_en/mem_we drop as soon as rst rises.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if ((state_reg == ST_ISSUE) && !led_sel_reg) begin
            mem_en = 1'b1;
            if (owner_reg == OWN_D) begin
                mem_we    = d_we;
                mem_addr  = d_addr[ADDR_WIDTH-1:2];
                mem_wdata = d_wdata;
            end else begin
                mem_addr  = if_addr[ADDR_WIDTH-1:2];
            end
        end
    end

    // Per-byte strobe gating; zero outside a memory write.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wstrb
            assign mem_wstrb[gi] = mem_en && wstrb_en && d_wstrb[gi];
        end
    endgenerate

    assign resp_word = led_sel_reg ? {{(DATA_WIDTH-8){1'b0}}, leds_reg} : mem_rdata;

    // Response: one-cycle ack to the owner in RESP; read data is zero otherwise.
    always_comb begin
        if_ack   = 1'b0;
        d_ack    = 1'b0;
        if_rdata = '0;
        d_rdata  = '0;
        if (state_reg == ST_RESP) begin
            if (owner_reg == OWN_D) begin
                d_ack   = 1'b1;
                d_rdata = resp_word;
            end else begin
                if_ack   = 1'b1;
                if_rdata = resp_word;
            end
        end
    end

    assign leds = leds_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: drivers push expected responses,
// a negedge monitor pops and compares on every ack. Memory contents and
// the LED value are predicted by a word/byte reference model.
module tb_mem_bus_arbiter;

    localparam logic [31:0] LED_A = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  leds;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LED_ADDR(LED_A)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .leds(leds)
    );

    // Simple synchronous word memory driven by the DUT (read returns old contents).
    logic [31:0] mem_arr [0:63];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we && mem_wstrb[b]) mem_arr[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
            mem_rdata <= mem_arr[mem_addr[5:0]];
        end
    end

    // Reference model state.
    logic [31:0] mem_ref [0:63];
    logic [7:0]  led_ref = 8'h00;

    // Scoreboard: bit 32 = compare data, bits 31:0 = expected data.
    logic [32:0] if_q[$];
    logic [32:0] d_q[$];
    bit          order_q[$];
    bit          record_order = 1'b0;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every ack against the scoreboard, and guards the idle/exclusive rules.
    always @(negedge clk) begin
        if (!rst) begin
            check("single_ack", 32'(if_ack & d_ack), 32'h0);
            if (if_ack) begin
                if (record_order) order_q.push_back(1'b0);
                if (if_q.size() == 0) begin
                    check("if_unexpected_ack", 32'(if_ack), 32'h0);
                end else begin
                    logic [32:0] e;
                    e = if_q.pop_front();
                    $display("if  ack rdata=%h", if_rdata);
                    if (e[32]) check("if_rdata", if_rdata, e[31:0]);
                end
            end else begin
                check("if_rdata_idle", if_rdata, 32'h0);
            end
            if (d_ack) begin
                if (record_order) order_q.push_back(1'b1);
                if (d_q.size() == 0) begin
                    check("d_unexpected_ack", 32'(d_ack), 32'h0);
                end else begin
                    logic [32:0] e;
                    e = d_q.pop_front();
                    $display("d   ack rdata=%h", d_rdata);
                    if (e[32]) check("d_rdata", d_rdata, e[31:0]);
                end
            end else begin
                check("d_rdata_idle", d_rdata, 32'h0);
            end
        end
    end

    // Fetch transaction; exp_lat>0 also checks ack arrives on that negedge.
    task automatic fetch_txn(input logic [31:0] addr, input int exp_lat,
                             output logic iss_en, output logic [29:0] iss_addr);
        int  n;
        bit  seen;
        iss_en   = 1'b0;
        iss_addr = '0;
        if_q.push_back({1'b1, mem_ref[addr[7:2]]});
        if_req  = 1'b1;
        if_addr = addr;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                iss_en   = mem_en;
                iss_addr = mem_addr;
            end
            if (if_ack) seen = 1'b1;
        end
        check("if_ack_seen", 32'(seen), 32'h1);
        if (seen && exp_lat > 0) check("if_latency", n, exp_lat);
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    // Data transaction; predicts the response from the reference model at issue time.
    task automatic data_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int exp_lat, output logic iss_en);
        int  n;
        bit  seen;
        logic [5:0] idx;
        idx = addr[7:2];
        iss_en = 1'b0;
        if (addr[31:2] == LED_A[31:2]) begin
            if (we && wstrb[0]) led_ref = wdata[7:0];
            d_q.push_back({~we, 24'h0, led_ref});
        end else begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) mem_ref[idx][b*8 +: 8] = wdata[b*8 +: 8];
            end
            d_q.push_back({~we, mem_ref[idx]});
        end
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_wstrb = wstrb;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) iss_en = mem_en;
            if (d_ack) seen = 1'b1;
        end
        check("d_ack_seen", 32'(seen), 32'h1);
        if (seen && exp_lat > 0) check("d_latency", n, exp_lat);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic do_reset();
        if_req = 1'b0;
        d_req  = 1'b0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        led_ref = 8'h00;
        if_q.delete();
        d_q.delete();
    endtask

    logic        ie;
    logic [29:0] ia;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = $urandom;
            mem_ref[i] = mem_arr[i];
        end
        mem_arr[2] = 32'h0050_0093;
        mem_ref[2] = 32'h0050_0093;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_if_ack", 32'(if_ack), 32'h0);
        check("rst_d_ack", 32'(d_ack), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        @(posedge clk);
        #1;

        // Fetch only
        fetch_txn(32'h8, 3, ie, ia);
        check("fetch_issue_en", 32'(ie), 32'h1);
        check("fetch_issue_addr", 32'(ia), 32'h2);

        // LED write then read back
        data_txn(1'b1, LED_A, 32'h0000_00A5, 4'hF, 3, ie);
        check("led_wr_mem_en", 32'(ie), 32'h0);
        check("led_value", 32'(leds), 32'hA5);
        data_txn(1'b0, LED_A, 32'h0, 4'h0, 3, ie);

        // LED to memory
        data_txn(1'b1, LED_A, 32'h0000_003C, 4'hF, 3, ie);
        data_txn(1'b0, LED_A, 32'h0, 4'h0, 3, ie);
        data_txn(1'b1, 32'd64, 32'h0000_003C, 4'hF, 3, ie);
        check("led_to_mem", mem_arr[16], 32'h0000_003C);

        // Byte strobe
        data_txn(1'b1, 32'd64, 32'h1122_3344, 4'hF, 3, ie);
        data_txn(1'b1, 32'd64, 32'hAABB_CCDD, 4'b0010, 3, ie);
        check("byte_strobe", mem_arr[16], 32'h1122_CC44);
        data_txn(1'b0, 32'd64, 32'h0, 4'h0, 3, ie);

        // Reset during ISSUE of a write to address 64
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd64; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("midop_issue_en", 32'(mem_en), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("midop_mem_en_drop", 32'(mem_en), 32'h0);
        check("midop_mem_we_drop", 32'(mem_we), 32'h0);
        d_req = 1'b0;
        d_we  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midop_no_ack", 32'(d_ack), 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        led_ref = 8'h00;
        check("midop_mem_unchanged", mem_arr[16], 32'h1122_CC44);
        check("midop_leds", 32'(leds), 32'h0);
        data_txn(1'b0, 32'd64, 32'h0, 4'h0, 3, ie);

        // Contention from reset: grants must alternate starting with fetch
        do_reset();
        record_order = 1'b1;
        fork
            begin
                logic        fe;
                logic [29:0] fa;
                for (int i = 0; i < 4; i++)
                    fetch_txn(32'(4 * $urandom_range(0, 15)), 0, fe, fa);
            end
            begin
                logic de;
                for (int j = 0; j < 4; j++)
                    data_txn(1'($urandom_range(0, 1)), 32'(64 + 4 * $urandom_range(0, 15)),
                             $urandom, 4'($urandom_range(0, 15)), 0, de);
            end
        join
        record_order = 1'b0;
        check("order_len", 32'(order_q.size()), 32'd8);
        for (int k = 0; k < order_q.size(); k++)
            check("order_alt", 32'(order_q[k]), 32'(k % 2));

        // Randomised traffic on both ports
        fork
            begin
                logic        fe;
                logic [29:0] fa;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    fetch_txn(32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3)), 0, fe, fa);
                end
            end
            begin
                logic de;
                for (int j = 0; j < 30; j++) begin
                    logic [31:0] a;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    if ($urandom_range(0, 4) == 0) a = LED_A + 32'($urandom_range(0, 3));
                    else a = 32'(64 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3));
                    data_txn(1'($urandom_range(0, 1)), a, $urandom,
                             4'($urandom_range(0, 15)), 0, de);
                end
            end
        join

        repeat (4) @(negedge clk);
        check("if_q_empty", 32'(if_q.size()), 32'h0);
        check("d_q_empty", 32'(d_q.size()), 32'h0);
        check("final_leds", 32'(leds), 32'(led_ref));
        for (int i = 0; i < 64; i++)
            check("final_mem", mem_arr[i], mem_ref[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
